// File: rtl/i2c_sequencer.sv
// i2c_sequencer: runs one START/address/data/STOP transaction on the I2C master.
// Ports: host descriptor (go/addr/rw/len), TX/RX FIFO access, master command side.
package i2c_pkg;
   typedef enum logic [2:0] {
      START_CMD   = 3'b000,
      WR_CMD      = 3'b001,
      RD_CMD      = 3'b010,
      STOP_CMD    = 3'b011,
      RESTART_CMD = 3'b100,
      NO_OP_CMD   = 3'b111
   } i2c_cmd_t;
endpackage

module i2c_sequencer
   import i2c_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       go,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] len,
   output logic       busy,
   output logic       done,
   output logic       nack_err,
   input  logic       tx_wr,
   input  logic [7:0] tx_wdata,
   output logic       tx_full,
   input  logic       rx_rd,
   output logic [7:0] rx_rdata,
   output logic       rx_empty,
   output i2c_cmd_t   m_cmd,
   output logic [7:0] m_din,
   output logic [6:0] m_slave_addr,
   output logic       m_en_i2c,
   output logic       m_en_wr,
   output logic       m_en_ack,
   output logic       m_tx_empty,
   output logic       m_rx_full,
   input  logic       m_ready,
   input  logic       m_done_tick,
   input  logic       m_ack,
   input  logic [7:0] m_dout
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

   typedef enum logic [2:0] {
      IDLE, START, ADDR, WDATA, RDATA, STOP_LO, STOP_HI
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] addr_q, addr_d;
   logic       dir_q, dir_d;
   logic [8:0] rem_q, rem_d;
   logic       nack_q, nack_d;

   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wp_q, tx_rp_q;
   logic [AW:0]   tx_cnt_q;
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0] rx_wp_q, rx_rp_q;
   logic [AW:0]   rx_cnt_q;

   logic tx_emp, rx_full_w;
   logic tx_push, tx_pop, rx_push, rx_pop;
   logic tx_pop_req, rx_push_req;

   assign tx_emp    = (tx_cnt_q == '0);
   assign tx_full   = (tx_cnt_q == FULL);
   assign rx_empty  = (rx_cnt_q == '0);
   assign rx_full_w = (rx_cnt_q == FULL);
   assign rx_rdata  = rx_mem[rx_rp_q];

   assign tx_push = tx_wr & ~tx_full;
   assign tx_pop  = tx_pop_req & ~tx_emp;
   assign rx_push = rx_push_req & ~rx_full_w;
   assign rx_pop  = rx_rd & ~rx_empty;

   assign busy         = (state_q != IDLE);
   assign nack_err     = nack_q;
   assign m_slave_addr = addr_q;
   assign m_en_i2c     = busy;
   assign m_en_wr      = busy & ~dir_q;
   assign m_rx_full    = rx_full_w;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      dir_d       = dir_q;
      rem_d       = rem_q;
      nack_d      = nack_q;
      tx_pop_req  = 1'b0;
      rx_push_req = 1'b0;
      done        = 1'b0;
      m_cmd       = NO_OP_CMD;
      m_din       = 8'hFF;
      m_tx_empty  = 1'b0;
      m_en_ack    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go) begin
               addr_d  = addr;
               // len==0 is an address-only probe, always sent as a write
               dir_d   = rw & (len != 8'd0);
               rem_d   = {1'b0, len};
               nack_d  = 1'b0;
               state_d = START;
            end
         end
         START: begin
            m_cmd = START_CMD;
            if (!m_ready) state_d = ADDR;
         end
         ADDR: begin
            m_cmd = dir_q ? RD_CMD : WR_CMD;
            if (m_done_tick) begin
               if (m_ack) begin
                  nack_d  = 1'b1;
                  state_d = STOP_LO;
               end else if (rem_q == 9'd0) begin
                  state_d = STOP_LO;
               end else begin
                  state_d = dir_q ? RDATA : WDATA;
               end
            end
         end
         WDATA: begin
            m_cmd      = WR_CMD;
            m_din      = tx_mem[tx_rp_q];
            // master stretches SCL until a byte is available
            m_tx_empty = tx_emp;
            if (m_done_tick) begin
               tx_pop_req = 1'b1;
               rem_d      = rem_q - 9'd1;
               if (m_ack) begin
                  nack_d  = 1'b1;
                  state_d = STOP_LO;
               end else if (rem_q == 9'd1) begin
                  state_d = STOP_LO;
               end
            end
         end
         RDATA: begin
            // withholding RD_CMD parks the master in hold while RX is full
            m_cmd    = rx_full_w ? NO_OP_CMD : RD_CMD;
            m_en_ack = (rem_q != 9'd1);
            if (m_done_tick) begin
               rx_push_req = 1'b1;
               rem_d       = rem_q - 9'd1;
               if (rem_q == 9'd1) state_d = STOP_LO;
            end
         end
         STOP_LO: begin
            m_cmd = STOP_CMD;
            if (!m_ready) state_d = STOP_HI;
         end
         STOP_HI: begin
            if (m_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         dir_q   <= 1'b0;
         rem_q   <= '0;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
         nack_q  <= nack_d;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
         if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
         tx_cnt_q <= tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
         rx_cnt_q <= rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp_q] <= tx_wdata;
      if (rx_push) rx_mem[rx_wp_q] <= m_dout;
   end
endmodule

// File: tb/tb_i2c_sequencer.sv
// tb_i2c_sequencer: transaction-level master/slave model plus host feeder and
// reader around i2c_sequencer; expected bus bytes derived from the descriptor.
module tb_i2c_sequencer;
   import i2c_pkg::*;
   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       go = 1'b0;
   logic [6:0] addr = '0;
   logic       rw = 1'b0;
   logic [7:0] len = '0;
   logic       busy, done, nack_err;
   logic       tx_wr;
   logic [7:0] tx_wdata;
   logic       tx_full;
   logic       rx_rd;
   logic [7:0] rx_rdata;
   logic       rx_empty;
   i2c_cmd_t   m_cmd;
   logic [7:0] m_din;
   logic [6:0] m_slave_addr;
   logic       m_en_i2c, m_en_wr, m_en_ack, m_tx_empty, m_rx_full;
   logic       m_ready, m_done_tick, m_ack;
   logic [7:0] m_dout;

   always #5 clk = ~clk;

   i2c_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .arst_n(arst_n), .go(go), .addr(addr), .rw(rw), .len(len),
      .busy(busy), .done(done), .nack_err(nack_err),
      .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_full(tx_full),
      .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
      .m_cmd(m_cmd), .m_din(m_din), .m_slave_addr(m_slave_addr),
      .m_en_i2c(m_en_i2c), .m_en_wr(m_en_wr), .m_en_ack(m_en_ack),
      .m_tx_empty(m_tx_empty), .m_rx_full(m_rx_full),
      .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack),
      .m_dout(m_dout)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // slave configuration (owned by main)
   bit         sl_present = 1'b1;
   int         sl_nack_idx = -1;
   logic [7:0] sl_rd[$];
   int         rd_en = 1;
   int         feed_limit = 32'h7fff_ffff;
   logic [7:0] tx_src[$];
   logic [7:0] tx_model[$];

   // master/bus model state (owned by the master process)
   typedef enum logic [2:0] {B_IDLE, B_START, B_HOLD, B_BYTE, B_STOP} bph_t;
   bph_t       ph;
   int         cnt, wr_idx, rd_idx, stops = 0, hold_cyc = 0;
   bit         first;
   logic       rsp_ack;
   logic [7:0] rsp_dat;
   logic [7:0] bus_q[$];
   bit         ena_q[$];

   task automatic launch();
      m_ready = 1'b0;
      cnt = $urandom_range(3, 8);
      ph = B_BYTE;
   endtask

   initial begin
      m_ready = 1'b1; m_done_tick = 1'b0; m_ack = 1'b0; m_dout = '0;
      ph = B_IDLE; cnt = 0; wr_idx = 0; rd_idx = 0; first = 1'b0;
      rsp_ack = 1'b0; rsp_dat = '0;
      forever begin
         tick();
         m_done_tick = 1'b0;
         if (!arst_n) begin
            ph = B_IDLE;
            m_ready = 1'b1;
         end else begin
            case (ph)
               B_IDLE: if (m_cmd == START_CMD) begin
                  m_ready = 1'b0;
                  cnt = $urandom_range(2, 5);
                  first = 1'b1; wr_idx = 0; rd_idx = 0;
                  ph = B_START;
               end
               B_START: begin
                  cnt--;
                  if (cnt == 0) begin m_ready = 1'b1; ph = B_HOLD; end
               end
               B_HOLD: begin
                  if (m_cmd == STOP_CMD) begin
                     m_ready = 1'b0; stops++;
                     cnt = $urandom_range(2, 5);
                     ph = B_STOP;
                  end else if ((m_cmd == WR_CMD || m_cmd == RD_CMD) && first) begin
                     bus_q.push_back({m_slave_addr, ~m_en_wr});
                     rsp_ack = !sl_present;
                     first = 1'b0;
                     launch();
                  end else if (m_cmd == WR_CMD && !m_tx_empty) begin
                     bus_q.push_back(m_din);
                     rsp_ack = (wr_idx == sl_nack_idx);
                     wr_idx++;
                     launch();
                  end else if (m_cmd == RD_CMD) begin
                     rsp_dat = (rd_idx < sl_rd.size()) ? sl_rd[rd_idx] : 8'hEE;
                     rd_idx++;
                     rsp_ack = !m_en_ack;
                     bus_q.push_back(rsp_dat);
                     ena_q.push_back(m_en_ack);
                     launch();
                  end else begin
                     hold_cyc++;
                  end
               end
               B_BYTE: begin
                  cnt--;
                  if (cnt == 0) begin
                     m_done_tick = 1'b1; m_ack = rsp_ack; m_dout = rsp_dat;
                     m_ready = 1'b1; ph = B_HOLD;
                  end
               end
               B_STOP: begin
                  cnt--;
                  if (cnt == 0) begin m_ready = 1'b1; ph = B_IDLE; end
               end
               default: ph = B_IDLE;
            endcase
         end
      end
   end

   // host TX feeder
   int feed_idx;
   initial begin
      tx_wr = 1'b0; tx_wdata = '0; feed_idx = 0;
      forever begin
         tick();
         tx_wr = 1'b0;
         if (!arst_n) feed_idx = tx_src.size();
         else if (feed_idx < tx_src.size() && feed_idx < feed_limit &&
                  !tx_full && $urandom_range(0, 3) != 0) begin
            tx_wr = 1'b1;
            tx_wdata = tx_src[feed_idx];
            feed_idx++;
         end
      end
   end

   // host RX reader
   logic [7:0] rx_got[$];
   initial begin
      rx_rd = 1'b0;
      forever begin
         tick();
         rx_rd = 1'b0;
         if (arst_n && rd_en != 0 && !rx_empty && $urandom_range(0, 2) != 0) begin
            rx_got.push_back(rx_rdata);
            rx_rd = 1'b1;
         end
      end
   end

   int done_cnt = 0;
   always @(negedge clk) if (arst_n && done) done_cnt++;

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] exp_bus[$];
   logic [7:0] exp_rx[$];
   bit         exp_ena[$];
   bit         exp_nack;
   int bus_base, ena_base, stop_base, done_base, rx_base, hold_base;

   task automatic host_push(input logic [7:0] b);
      tx_src.push_back(b);
      tx_model.push_back(b);
   endtask

   task automatic wait_fed();
      int n = 0;
      while (feed_idx < tx_src.size() && n < 500) begin tick(); n++; end
      tick();
   endtask

   task automatic start_txn(input logic [6:0] a, input bit r, input int l);
      bit d;
      logic [7:0] b;
      exp_bus.delete(); exp_rx.delete(); exp_ena.delete();
      d = r && (l != 0);
      exp_bus.push_back({a, d});
      exp_nack = 1'b0;
      if (!sl_present) exp_nack = 1'b1;
      else if (d) begin
         for (int i = 0; i < l; i++) begin
            exp_bus.push_back(sl_rd[i]);
            exp_rx.push_back(sl_rd[i]);
            exp_ena.push_back(i != l - 1);
         end
      end else begin
         for (int i = 0; i < l; i++) begin
            b = tx_model.pop_front();
            exp_bus.push_back(b);
            if (i == sl_nack_idx) begin exp_nack = 1'b1; break; end
         end
      end
      bus_base = bus_q.size(); ena_base = ena_q.size(); stop_base = stops;
      done_base = done_cnt; rx_base = rx_got.size(); hold_base = hold_cyc;
      addr = a; rw = r; len = 8'(l); go = 1'b1;
      tick();
      go = 1'b0;
      check("go_busy", busy, 1);
      check("go_nack_clr", nack_err, 0);
   endtask

   task automatic finish_txn();
      int n = 0;
      rd_en = 1;
      while (busy !== 1'b0 && n < 5000) begin tick(); n++; end
      check("txn_busy_timeout", busy, 0);
      n = 0;
      while (rx_got.size() - rx_base < exp_rx.size() && n < 500) begin
         tick(); n++;
      end
      check("nack_err", nack_err, exp_nack);
      check("done_pulses", done_cnt - done_base, 1);
      check("stops", stops - stop_base, 1);
      check("bus_len", bus_q.size() - bus_base, exp_bus.size());
      for (int i = 0; i < exp_bus.size(); i++)
         check("bus_byte", (bus_base + i < bus_q.size()) ?
               32'(bus_q[bus_base + i]) : 32'hFFFF, exp_bus[i]);
      for (int i = 0; i < exp_ena.size(); i++)
         check("rd_ack_en", (ena_base + i < ena_q.size()) ?
               32'(ena_q[ena_base + i]) : 32'hFFFF, exp_ena[i]);
      check("rx_len", rx_got.size() - rx_base, exp_rx.size());
      for (int i = 0; i < exp_rx.size(); i++)
         check("rx_byte", (rx_base + i < rx_got.size()) ?
               32'(rx_got[rx_base + i]) : 32'hFFFF, exp_rx[i]);
      check("rx_empty_end", rx_empty, 1);
   endtask

   initial begin
      int n, l, r;
      logic [6:0] a;
      repeat (4) tick();
      arst_n = 1'b1;
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_nack", nack_err, 0);
      check("rst_cmd", m_cmd, NO_OP_CMD);
      check("rst_en_i2c", m_en_i2c, 0);
      check("rst_en_wr", m_en_wr, 0);
      check("rst_en_ack", m_en_ack, 0);
      check("rst_saddr", m_slave_addr, 0);
      check("rst_rx_empty", rx_empty, 1);
      check("rst_tx_full", tx_full, 0);

      // write 2 bytes with preloaded TX
      host_push(8'hA5); host_push(8'h3C);
      wait_fed();
      check("tx_full_preload", tx_full, 1);
      start_txn(7'h50, 0, 2);
      finish_txn();
      check("tx_drained", tx_full, 0);

      // address NACK; byte stays queued
      sl_present = 1'b0;
      host_push(8'h11);
      start_txn(7'h51, 0, 1);
      finish_txn();
      sl_present = 1'b1;
      start_txn(7'h12, 0, 1);
      finish_txn();

      // read 3 bytes
      sl_rd = '{8'h01, 8'h02, 8'h03};
      start_txn(7'h33, 1, 3);
      finish_txn();

      // TX underflow: bytes released one at a time
      feed_limit = feed_idx;
      host_push(8'h77); host_push(8'h88);
      start_txn(7'h44, 0, 2);
      repeat (60) tick();
      check("uf_wait_bus", bus_q.size() - bus_base, 1);
      check("uf_busy", busy, 1);
      check("uf_held", hold_cyc > hold_base, 1);
      feed_limit = feed_idx + 1;
      repeat (60) tick();
      check("uf_one_bus", bus_q.size() - bus_base, 2);
      feed_limit = 32'h7fff_ffff;
      finish_txn();

      // RX backpressure
      rd_en = 0;
      sl_rd = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      start_txn(7'h60, 1, 4);
      repeat (150) tick();
      check("bp_bus", bus_q.size() - bus_base, 3);
      check("bp_rx_full", m_rx_full, 1);
      check("bp_cmd", m_cmd, NO_OP_CMD);
      check("bp_din", m_din, 8'hFF);
      check("bp_busy", busy, 1);
      finish_txn();

      // reset mid-WDATA
      feed_limit = feed_idx + 1;
      host_push(8'h5A); host_push(8'h6B); host_push(8'h7C);
      start_txn(7'h70, 0, 3);
      n = 0;
      while (bus_q.size() - bus_base < 2 && n < 2000) begin tick(); n++; end
      repeat (20) tick();
      check("rm_busy_pre", busy, 1);
      @(posedge clk);
      #3 arst_n = 1'b0;
      #1;
      check("rm_busy", busy, 0);
      check("rm_cmd", m_cmd, NO_OP_CMD);
      check("rm_en_i2c", m_en_i2c, 0);
      check("rm_rx_empty", rx_empty, 1);
      check("rm_tx_full", tx_full, 0);
      repeat (3) @(posedge clk);
      #3 arst_n = 1'b1;
      tx_model.delete();
      feed_limit = 32'h7fff_ffff;
      repeat (3) tick();
      host_push(8'hD1); host_push(8'hD2);
      wait_fed();
      check("rm_tx_full_after", tx_full, 1);
      start_txn(7'h2A, 0, 2);
      finish_txn();

      // randomized transactions
      for (int t = 0; t < 20; t++) begin
         r = $urandom_range(0, 1);
         l = $urandom_range(0, 6);
         a = 7'($urandom_range(0, 127));
         sl_present = ($urandom_range(0, 7) != 0);
         sl_nack_idx = -1;
         if (l > 0 && $urandom_range(0, 3) == 0)
            sl_nack_idx = $urandom_range(0, l - 1);
         sl_rd.delete();
         for (int i = 0; i < l; i++) sl_rd.push_back(8'($urandom_range(0, 255)));
         if (r == 0)
            while (tx_model.size() < l) host_push(8'($urandom_range(0, 255)));
         start_txn(a, r[0], l);
         finish_txn();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/i2c_sequencer.md
Name: i2c_sequencer

Overview:
- Transaction sequencer that sits directly upstream of the I2C master controller, in the MMIO I2C subsystem.
- Accepts one host transaction descriptor (slave address, direction, byte count) and owns a TX FIFO and an RX FIFO.
- Drives the master's cmd/din/en_* /tx_empty/rx_full inputs to run START -> address -> N data bytes -> STOP.
- Consumes the master's ready/done_tick/ack/dout outputs. Repeated START is not supported; one transaction per go.

Parameters:
FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs (power of 2, >=2).

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
go  in  1  one-cycle pulse: start transaction; ignored while busy
addr  in  7  target slave address, sampled on go
rw  in  1  1=read, 0=write, sampled on go
len  in  8  data byte count 0..255, sampled on go
busy  out  1  transaction in progress
done  out  1  one-cycle pulse when the master returns to idle after STOP
nack_err  out  1  sticky: slave NACKed address or a write byte; cleared on next accepted go
tx_wr  in  1  push tx_wdata into TX FIFO (dropped if tx_full)
tx_wdata  in  8  write data
tx_full  out  1  TX FIFO full
rx_rd  in  1  pop RX FIFO (ignored if rx_empty)
rx_rdata  out  8  RX FIFO head (first-word fall-through)
rx_empty  out  1  RX FIFO empty
m_cmd  out  i2c_cmd_t  command to master
m_din  out  8  data to master
m_slave_addr  out  7  latched addr
m_en_i2c  out  1  =busy
m_en_wr  out  1  1 during write or probe transactions
m_en_ack  out  1  master ACK enable for read bytes
m_tx_empty  out  1  byte-unavailable indication to master
m_rx_full  out  1  RX FIFO full
m_ready  in  1  master ready
m_done_tick  in  1  master byte complete
m_ack  in  1  9th bit sampled by master (0=ACK)
m_dout  in  8  byte read by master

Behaviour:
- Reset: state IDLE, both FIFOs empty, busy=0, done=0, nack_err=0, m_cmd=NO_OP_CMD, m_en_i2c=0, m_en_wr=0, m_en_ack=0, m_slave_addr=0, rem=0. Reset mid-transaction aborts immediately with no STOP generated; the master shares arst_n.
- Probe: len=0 is an address-only probe with write direction regardless of rw.
- m_cmd is combinational from state. Latched regs: addr_q, dir_q (read && len!=0), rem (9 bit).
- IDLE: on go, latch descriptor, clear nack_err, -> START.
- START: m_cmd=START_CMD. When m_ready=0 (master has left its idle state) -> ADDR.
- ADDR: m_cmd = dir_q ? RD_CMD : WR_CMD; m_tx_empty=0; m_en_wr = ~dir_q.
  - On m_done_tick: m_ack=1 sets nack_err and -> STOP_LO.
  - Otherwise: rem==0 -> STOP_LO; dir_q -> RDATA; else -> WDATA.
- WDATA: m_din = TX head; m_tx_empty = TX empty, so the master holds SCL low until a byte arrives; m_cmd=WR_CMD.
  - On m_done_tick: pop TX, rem-=1.
  - If m_ack=1: set nack_err, -> STOP_LO; remaining TX bytes stay queued.
  - Else if rem reaches 0 -> STOP_LO.
- RDATA: m_din=8'hFF; m_tx_empty=0; m_cmd = RX full ? NO_OP_CMD : RD_CMD (the master idles in hold while RX is full); m_en_ack = (rem!=1), so the last byte is NACKed.
  - On m_done_tick: push m_dout to RX, rem-=1; rem reaches 0 -> STOP_LO.
  - At most one byte is in flight; the full flag updates the cycle after the push, before the master's next command sample.
- STOP_LO: m_cmd=STOP_CMD; wait m_ready=0 -> STOP_HI.
- STOP_HI: m_cmd=NO_OP_CMD; on m_ready=1 -> pulse done, -> IDLE.
- busy=1 in every state except IDLE.
- FIFOs: tx_wr and a pop in the same cycle are both honoured. A push when full is dropped; a pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Host tx_wr and rx_rd remain legal while busy.

Test Plan:
- Write probe-then-data: preload TX {8'hA5, 8'h3C}, go addr=7'h50 rw=0 len=2, slave ACKs all -> bus bytes 0xA0, 0xA5, 0x3C, STOP; done pulses once; nack_err=0; TX empty.
- Address NACK: go addr=7'h51 rw=0 len=1, TX {8'h11}, no slave -> nack_err=1, STOP issued after the address byte, 8'h11 still in TX, done pulses.
- Read 3 bytes: slave returns 0x01, 0x02, 0x03 -> master ACK, ACK, NACK on the bus; RX pops 0x01, 0x02, 0x03 in order; done once.
- TX underflow: go write len=2 with TX empty; push 8'h77 after 5 bit-times -> SCL held low until the push, then byte 0x77 is sent; second byte waits likewise.
- RX backpressure, FIFO_DEPTH=2: read len=4, no rx_rd -> after 2 bytes the master idles with SCL low; pop one entry -> the third byte is transferred.
- Reset mid-WDATA: assert arst_n low -> busy=0, FIFOs empty, m_cmd=NO_OP_CMD next edge; a new go after release completes normally.
